// File: rtl/sum_accum_if.sv
// sum_accum_if: upstream beat stream, result handshake and status for sum_accum.
interface sum_accum_if #(
  parameter int IN_WIDTH  = 33,
  parameter int CNT_WIDTH = 8
);
  localparam int ACC_WIDTH = IN_WIDTH + CNT_WIDTH;
  logic                 iStart;
  logic [CNT_WIDTH-1:0] iLen;
  logic                 iValid;
  logic [IN_WIDTH-1:0]  iData;
  logic                 oReady;
  logic                 oValid;
  logic                 iReady;
  logic [ACC_WIDTH-1:0] oData;
  logic [CNT_WIDTH-1:0] oCount;
  logic                 oBusy;
  modport master (
    output iStart, iLen, iValid, iData, iReady,
    input  oReady, oValid, oData, oCount, oBusy
  );
  modport slave (
    input  iStart, iLen, iValid, iData, iReady,
    output oReady, oValid, oData, oCount, oBusy
  );
endinterface

// File: rtl/sum_accum.sv
// sum_accum: accumulates a burst of iLen unsigned sums, then holds the total until taken.
module sum_accum #(
  parameter int IN_WIDTH  = 33,
  parameter int CNT_WIDTH = 8
) (
  input logic iClk,
  input logic iRst,
  sum_accum_if.slave bus
);
  localparam int ACC_WIDTH = IN_WIDTH + CNT_WIDTH;
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  state_t               r_state, w_next;
  logic [ACC_WIDTH-1:0] r_acc;
  logic [CNT_WIDTH-1:0] r_cnt, r_len;
  logic                 w_xfer, w_last;
  assign w_xfer = (r_state == ACCUM) && bus.iValid;
  assign w_last = w_xfer && (CNT_WIDTH'(r_cnt + 1'b1) == r_len);
  always_ff @(posedge iClk or posedge iRst)
    if (iRst) r_state <= IDLE;
    else      r_state <= w_next;
  always_comb begin
    w_next = r_state;
    w_next = r_state == IDLE  ? (bus.iStart ? (bus.iLen == '0 ? DONE : ACCUM) : IDLE) :
             r_state == ACCUM ? (w_last ? DONE : ACCUM) :
             r_state == DONE  ? (bus.iReady ? IDLE : DONE) : IDLE;
  end
  // Accumulator is wide enough for the longest burst, so no wrap handling.
  always_ff @(posedge iClk or posedge iRst)
    if (iRst) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_len <= '0;
    end else if (r_state == IDLE && bus.iStart) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_len <= bus.iLen;
    end else if (w_xfer) begin
      r_acc <= r_acc + ACC_WIDTH'(bus.iData);
      r_cnt <= r_cnt + 1'b1;
    end
  assign bus.oReady = r_state == ACCUM;
  assign bus.oValid = r_state == DONE;
  assign bus.oBusy  = r_state != IDLE;
  assign bus.oData  = r_acc;
  assign bus.oCount = r_cnt;
endmodule

// File: tb/tb_sum_accum.sv
// tb_sum_accum: scoreboard-driven check of burst accumulation, backpressure and reset.
module tb_sum_accum;
  localparam int IW = 33;
  localparam int CW = 8;
  logic clk = 0;
  logic rst = 1;
  int n_chk = 0;
  int n_err = 0;
  logic [63:0] sb[$];
  logic [63:0] beats[$];
  sum_accum_if #(.IN_WIDTH(IW), .CNT_WIDTH(CW)) bus ();
  sum_accum #(.IN_WIDTH(IW), .CNT_WIDTH(CW)) dut (.iClk(clk), .iRst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_start(input int len);
    bus.iStart = 1;
    bus.iLen   = CW'(len);
    tick();
    bus.iStart = 0;
    check("start_busy", bus.oBusy, 1);
    check("start_ready", bus.oReady, len != 0);
    check("start_count", bus.oCount, 0);
  endtask
  task automatic run_burst(input int gap, input int hold, input bit pulse);
    logic [63:0] exp = 0;
    logic [63:0] res;
    foreach (beats[i]) exp += beats[i];
    sb.push_back(exp);
    do_start(beats.size());
    foreach (beats[i]) begin
      check("beat_ready", bus.oReady, 1);
      bus.iValid = 1;
      bus.iData  = beats[i][IW-1:0];
      tick();
      bus.iValid = 0;
      if (i != beats.size() - 1) repeat (gap) begin
        tick();
        check("gap_count", bus.oCount, i + 1);
      end
    end
    check("done_valid", bus.oValid, 1);
    check("done_ready", bus.oReady, 0);
    res = sb.pop_front();
    check("result", bus.oData, res);
    check("count", bus.oCount, beats.size());
    bus.iStart = pulse;
    repeat (hold) begin
      tick();
      check("hold_valid", bus.oValid, 1);
      check("hold_data", bus.oData, res);
      check("hold_count", bus.oCount, beats.size());
    end
    bus.iReady = 1;
    tick();
    bus.iReady = 0;
    bus.iStart = 0;
    check("after_valid", bus.oValid, 0);
    check("after_busy", bus.oBusy, 0);
    check("after_data", bus.oData, res);
    tick();
    check("idle_busy", bus.oBusy, 0);
  endtask
  initial begin
    #1000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
  initial begin
    bus.iStart = 0; bus.iLen = 0; bus.iValid = 0; bus.iData = 0; bus.iReady = 0;
    #2;
    check("rst_ready", bus.oReady, 0);
    check("rst_valid", bus.oValid, 0);
    check("rst_busy", bus.oBusy, 0);
    check("rst_data", bus.oData, 0);
    check("rst_count", bus.oCount, 0);
    repeat (2) tick();
    rst = 0;
    tick();
    check("idle_busy0", bus.oBusy, 0);
    // iReady outside DONE must have no effect
    bus.iReady = 1;
    tick();
    bus.iReady = 0;
    check("ready_idle", bus.oBusy, 0);
    beats = '{10, 20, 30, 40};
    run_burst(0, 0, 0);
    beats = '{5, 6, 7};
    run_burst(2, 3, 1);
    beats = '{};
    run_burst(0, 1, 0);
    beats = '{};
    for (int i = 0; i < 255; i++) beats.push_back(64'h1_FFFF_FFFF);
    run_burst(0, 0, 0);
    check("max_const", bus.oData, 64'd2190433320705);
    beats = '{3};
    run_burst(0, 0, 0);
    do_start(4);
    for (int i = 1; i <= 2; i++) begin
      bus.iValid = 1;
      bus.iData  = IW'(i);
      tick();
    end
    bus.iValid = 0;
    check("mid_count", bus.oCount, 2);
    check("mid_data", bus.oData, 3);
    rst = 1;
    #1;
    check("arst_busy", bus.oBusy, 0);
    check("arst_ready", bus.oReady, 0);
    check("arst_data", bus.oData, 0);
    check("arst_count", bus.oCount, 0);
    rst = 0;
    tick();
    check("arst_idle", bus.oBusy, 0);
    check("arst_valid", bus.oValid, 0);
    beats = '{7};
    run_burst(0, 0, 0);
    for (int k = 0; k < 6; k++) begin
      beats = '{};
      for (int j = 0; j < 1 + k; j++) beats.push_back(64'($urandom) & 64'h1_FFFF_FFFF);
      run_burst(k % 3, k % 2, k[0]);
    end
    check("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
